fx_slide_detect: RTL and testbench

//  Receive-side counterpart of the slide effect: watches a note stream, one sample per note_clk.

---
 rtl/fx_pkg.sv | 24 ++
 rtl/fx_note_delta.sv | 35 +++
 rtl/fx_slide_detect.sv | 148 ++++++++++++++
 tb/tb_fx_slide_detect.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared encodings for the slide detector (states, directions, delta classes)
package fx_pkg;

  localparam int NOTE_W = 6;

  typedef enum logic [2:0] {
    ACQ,
    STEP1,
    STEP2,
    VERIFY,
    LOCKED
  } fx_state_t;

  typedef enum logic [1:0] {
    SAME,
    UP,
    DOWN,
    JUMP
  } delta_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/fx_note_delta.sv
// rtl/fx_note_delta.sv - classifies consecutive notes as SAME/UP/DOWN/JUMP
// FX_SLIDE_DET_WRAP_EN: when defined, 63->0 is UP and 0->63 is DOWN; otherwise both are JUMP.
module fx_note_delta
  import fx_pkg::*;
(
  input  logic [NOTE_W-1:0] prev_note,
  input  logic [NOTE_W-1:0] cur_note,
  output delta_t            delta
);

  logic [NOTE_W-1:0] diff;
  logic              wrap_block;

`ifdef FX_SLIDE_DET_WRAP_EN
  assign wrap_block = 1'b0;
`else
  assign wrap_block = (prev_note == '1 && cur_note == '0) ||
                      (prev_note == '0 && cur_note == '1);
`endif

  assign diff = cur_note - prev_note;

  always_comb begin
    delta = JUMP;
    if (diff == '0)
      delta = SAME;
    else if (wrap_block)
      delta = JUMP;
    else if (diff == NOTE_W'(1))
      delta = UP;
    else if (diff == '1)
      delta = DOWN;
  end

endmodule

// File: rtl/fx_slide_detect.sv
// rtl/fx_slide_detect.sv - recovers base note, direction, speed and step count of a note slide
// Build option FX_SLIDE_DET_WRAP_EN (see fx_note_delta) lets runs continue across the 63/0 wrap.
module fx_slide_detect
  import fx_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int STEP_W   = 8
) (
  input  logic              note_clk,
  input  logic              rst,
  input  logic [5:0]        note_in,
  input  logic              note_valid,
  output logic [5:0]        base_note,
  output logic [1:0]        direction,
  output logic [1:0]        speed,
  output logic [STEP_W-1:0] slide_steps,
  output logic              locked,
  output logic              slide_break
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  fx_state_t         state, state_nx;
  delta_t            delta;
  logic [5:0]        prev_note;
  logic [HOLD_W-1:0] hold, hold_nx, hold_inc;
  logic [HOLD_W-1:0] cand_int, cand_int_nx;
  logic [5:0]        cand_base, cand_base_nx;
  logic              cand_dir, cand_dir_nx;
  logic              is_step, step_fwd;
  logic              do_lock, do_adv, do_break;

  fx_note_delta u_delta (
    .prev_note (prev_note),
    .cur_note  (note_in),
    .delta     (delta)
  );

  always_comb begin
    state_nx     = state;
    hold_nx      = hold;
    cand_int_nx  = cand_int;
    cand_base_nx = cand_base;
    cand_dir_nx  = cand_dir;
    do_lock      = 1'b0;
    do_adv       = 1'b0;
    do_break     = 1'b0;
    hold_inc     = (hold == HOLD_SAT) ? hold : hold + HOLD_ONE;
    is_step      = (delta == UP) || (delta == DOWN);
    step_fwd     = is_step && ((delta == UP) == cand_dir);

    if (note_valid) begin
      hold_nx = (delta == SAME) ? hold_inc : HOLD_ONE;
      case (state)
        ACQ: begin
          hold_nx  = HOLD_ONE;
          state_nx = STEP1;
        end
        // The hold before the first step has an unknown start phase, so only the direction counts.
        STEP1: begin
          if (is_step) begin
            cand_base_nx = prev_note;
            cand_dir_nx  = (delta == UP) ? DIR_UP : DIR_DOWN;
            state_nx     = STEP2;
          end
        end
        STEP2: begin
          if (delta == SAME) begin
            if (hold_inc > HOLD_MAX)
              state_nx = STEP1;
          end else if (step_fwd) begin
            cand_int_nx = hold;
            state_nx    = VERIFY;
          end else begin
            state_nx = STEP1;
          end
        end
        VERIFY: begin
          if (delta == SAME) begin
            if (hold_inc > cand_int)
              state_nx = STEP1;
          end else if (step_fwd && hold == cand_int) begin
            do_lock  = 1'b1;
            state_nx = LOCKED;
          end else begin
            state_nx = STEP1;
          end
        end
        LOCKED: begin
          if (delta == SAME) begin
            if (hold_inc > cand_int) begin
              do_break = 1'b1;
              state_nx = STEP1;
            end
          end else if (step_fwd && hold == cand_int) begin
            do_adv = 1'b1;
          end else begin
            do_break = 1'b1;
            state_nx = STEP1;
          end
        end
        default: state_nx = ACQ;
      endcase
    end
  end

  always_ff @(posedge note_clk or posedge rst) begin
    if (rst) begin
      state       <= ACQ;
      prev_note   <= '0;
      hold        <= '0;
      cand_int    <= '0;
      cand_base   <= '0;
      cand_dir    <= DIR_DOWN;
      base_note   <= '0;
      direction   <= '0;
      speed       <= '0;
      slide_steps <= '0;
      locked      <= 1'b0;
      slide_break <= 1'b0;
    end else begin
      state       <= state_nx;
      hold        <= hold_nx;
      cand_int    <= cand_int_nx;
      cand_base   <= cand_base_nx;
      cand_dir    <= cand_dir_nx;
      slide_break <= do_break;
      if (note_valid)
        prev_note <= note_in;
      // Three matching steps are already behind us when the lock is taken.
      if (do_lock) begin
        locked      <= 1'b1;
        base_note   <= cand_base;
        direction   <= {1'b0, cand_dir};
        speed       <= 2'(cand_int - HOLD_ONE);
        slide_steps <= STEP_W'(3);
      end
      if (do_adv && slide_steps != '1)
        slide_steps <= slide_steps + 1'b1;
      if (do_break)
        locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fx_slide_detect.sv
// tb/tb_fx_slide_detect.sv - randomized self-checking bench for fx_slide_detect with a streak-count reference model
`timescale 1ns/1ps
module tb_fx_slide_detect;

  localparam int MAX_HOLD = 4;
  localparam int STEP_W   = 8;

  logic              note_clk = 1'b0;
  logic              rst = 1'b1;
  logic [5:0]        note_in = '0;
  logic              note_valid = 1'b0;
  logic [5:0]        base_note;
  logic [1:0]        direction;
  logic [1:0]        speed;
  logic [STEP_W-1:0] slide_steps;
  logic              locked;
  logic              slide_break;

  fx_slide_detect #(.MAX_HOLD(MAX_HOLD), .STEP_W(STEP_W)) dut (
    .note_clk    (note_clk),
    .rst         (rst),
    .note_in     (note_in),
    .note_valid  (note_valid),
    .base_note   (base_note),
    .direction   (direction),
    .speed       (speed),
    .slide_steps (slide_steps),
    .locked      (locked),
    .slide_break (slide_break)
  );

  always #5 note_clk = ~note_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts consecutive consistent steps (streak) instead of tracking FSM states.
  bit          m_started;
  int          m_prev, m_run, m_streak, m_int, m_cbase;
  bit          m_dir;
  logic [5:0]  m_base_o;
  logic        m_dir_o;
  logic [1:0]  m_speed_o;
  logic [7:0]  m_steps_o;
  bit          m_locked, m_break;

  function automatic int classify(int prev, int cur);
    int d;
    d = (cur - prev + 64) % 64;
`ifndef FX_SLIDE_DET_WRAP_EN
    if ((prev == 63 && cur == 0) || (prev == 0 && cur == 63)) return 2;
`endif
    if (d == 0)  return 0;
    if (d == 1)  return 1;
    if (d == 63) return -1;
    return 2;
  endfunction

  task automatic model_reset();
    m_started = 0; m_prev = 0; m_run = 0; m_streak = 0; m_int = 0; m_cbase = 0; m_dir = 0;
    m_base_o = '0; m_dir_o = 0; m_speed_o = '0; m_steps_o = '0; m_locked = 0; m_break = 0;
  endtask

  task automatic model_end_run();
    if (m_streak >= 3) begin
      m_locked = 0;
      m_break  = 1;
    end
    m_streak = 0;
  endtask

  task automatic model_step(input bit v, input int note);
    int  c, limit;
    bit  fwd;
    m_break = 0;
    if (!v) return;
    if (!m_started) begin
      m_started = 1; m_prev = note; m_run = 1; m_streak = 0;
      return;
    end
    c = classify(m_prev, note);
    if (c == 0) begin
      if (m_run <= MAX_HOLD) m_run = m_run + 1;
      limit = (m_streak == 1) ? MAX_HOLD : m_int;
      if (m_streak >= 1 && m_run > limit) model_end_run();
    end else if (c == 2) begin
      model_end_run();
      m_run = 1;
    end else begin
      fwd = ((c == 1) == m_dir);
      if (m_streak == 0) begin
        m_cbase = m_prev; m_dir = (c == 1); m_streak = 1;
      end else if (m_streak == 1) begin
        if (fwd) begin m_int = m_run; m_streak = 2; end
        else m_streak = 0;
      end else if (fwd && m_run == m_int) begin
        if (m_streak == 2) begin
          m_streak = 3; m_locked = 1; m_base_o = 6'(m_cbase); m_dir_o = m_dir;
          m_speed_o = 2'(m_int - 1); m_steps_o = 8'd3;
        end else if (m_steps_o != 8'hFF) begin
          m_steps_o = m_steps_o + 8'd1;
        end
      end else begin
        model_end_run();
      end
      m_run = 1;
    end
    m_prev = note;
  endtask

  function automatic logic [19:0] dut_vec();
    return {base_note, direction, speed, slide_steps, locked, slide_break};
  endfunction

  function automatic logic [19:0] mdl_vec();
    return {m_base_o, 1'b0, m_dir_o, m_speed_o, m_steps_o, m_locked, m_break};
  endfunction

  task automatic drive(input logic [5:0] n, input logic v);
    @(negedge note_clk);
    note_in = n;
    note_valid = v;
    @(posedge note_clk);
    model_step(v, int'(n));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge note_clk);
    rst = 1'b1;
    note_valid = 1'b0;
    model_reset();
    @(negedge note_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge note_clk);
    n_tests++;
    if (dut_vec() !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), 20'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_up_speed1();
    int seq [7] = '{20, 20, 21, 21, 22, 22, 23};
    apply_reset();
    foreach (seq[i]) begin
      drive(6'(seq[i]), 1'b1);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL up_speed1 s%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i == 5) begin
        n_tests++;
        if (locked !== 1'b0) begin
          n_fail++; $display("FAIL up_speed1_early_lock: got %b want 0", locked);
        end
      end
    end
    n_tests++;
    if ({base_note, direction, speed, slide_steps, locked} !== {6'd20, 2'b01, 2'd1, 8'd3, 1'b1}) begin
      n_fail++; $display("FAIL up_speed1_params: got %h want %h",
        {base_note, direction, speed, slide_steps, locked}, {6'd20, 2'b01, 2'd1, 8'd3, 1'b1});
    end
  endtask

  task automatic test_down_break();
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      drive(6'(40 - (i < 12 ? i / 4 : 3)), 1'b1);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL down_break s%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i == 12) begin
        n_tests++;
        if ({base_note, direction, speed, slide_steps, locked} !== {6'd40, 2'b00, 2'd3, 8'd3, 1'b1}) begin
          n_fail++; $display("FAIL down_lock_params: got %h want %h",
            {base_note, direction, speed, slide_steps, locked}, {6'd40, 2'b00, 2'd3, 8'd3, 1'b1});
        end
      end
      if (i == 16) begin
        n_tests++;
        if ({slide_break, locked, speed} !== {1'b1, 1'b0, 2'd3}) begin
          n_fail++; $display("FAIL down_overrun_break: got %b want %b", {slide_break, locked, speed}, 4'b1011);
        end
      end
    end
  endtask

  task automatic test_jump_relock();
    int b, j;
    b = $urandom_range(5, 40);
    j = b + 9;
    apply_reset();
    for (int i = 0; i < 5; i++) drive(6'(b + i), 1'b1);
    drive(6'(j), 1'b1);
    n_tests++;
    if ({slide_break, locked, slide_steps} !== {1'b1, 1'b0, 8'd4}) begin
      n_fail++; $display("FAIL jump_break: got %h want %h", {slide_break, locked, slide_steps}, {1'b1, 1'b0, 8'd4});
    end
    for (int i = 1; i <= 3; i++) begin
      drive(6'(j + i), 1'b1);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL jump_relock s%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    n_tests++;
    if ({base_note, locked, slide_steps, speed} !== {6'(j), 1'b1, 8'd3, 2'd0}) begin
      n_fail++; $display("FAIL relock_base: got %h want %h", {base_note, locked, slide_steps, speed}, {6'(j), 1'b1, 8'd3, 2'd0});
    end
  endtask

  task automatic test_wrap();
    int seq [6] = '{60, 61, 62, 63, 0, 1};
    apply_reset();
    foreach (seq[i]) begin
      drive(6'(seq[i]), 1'b1);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL wrap s%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i == 4) begin
        n_tests++;
`ifdef FX_SLIDE_DET_WRAP_EN
        if ({locked, slide_break, slide_steps} !== {1'b1, 1'b0, 8'd4}) begin
          n_fail++; $display("FAIL wrap_continue: got %h want %h", {locked, slide_break, slide_steps}, {1'b1, 1'b0, 8'd4});
        end
`else
        if ({locked, slide_break} !== 2'b01) begin
          n_fail++; $display("FAIL wrap_break: got %b want 01", {locked, slide_break});
        end
`endif
      end
    end
  endtask

  task automatic test_valid_gap();
    int b;
    logic [19:0] held;
    b = $urandom_range(2, 50);
    apply_reset();
    for (int i = 0; i < 10; i++) drive(6'(b + (i < 9 ? i / 3 : 3)), 1'b1);
    held = dut_vec();
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL gap_prelock: got %b want 1", locked);
    end
    for (int i = 0; i < 10; i++) begin
      drive(6'($urandom_range(0, 63)), 1'b0);
      n_tests++;
      if (dut_vec() !== mdl_vec() || dut_vec() !== held) begin
        n_fail++; $display("FAIL gap_hold t%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    drive(6'(b + 3), 1'b1);
    drive(6'(b + 3), 1'b1);
    drive(6'(b + 4), 1'b1);
    n_tests++;
    if ({locked, slide_break, slide_steps, speed} !== {1'b1, 1'b0, 8'd4, 2'd2}) begin
      n_fail++; $display("FAIL gap_resume: got %h want %h", {locked, slide_break, slide_steps, speed}, {1'b1, 1'b0, 8'd4, 2'd2});
    end
  endtask

  task automatic test_reset_midrun();
    int b, spd, h;
    apply_reset();
    for (int i = 0; i < 6; i++) drive(6'(30 - i), 1'b1);
    @(negedge note_clk);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (dut_vec() !== 20'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec(), 20'h0);
    end
    model_reset();
    @(negedge note_clk);
    rst = 1'b0;
    b = $urandom_range(4, 50);
    spd = $urandom_range(0, 3);
    h = spd + 1;
    for (int i = 0; i < 3 * h + 1; i++) begin
      drive(6'(b + (i / h)), 1'b1);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL post_reset s%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    n_tests++;
    if ({locked, base_note, speed, direction} !== {1'b1, 6'(b), 2'(spd), 2'b01}) begin
      n_fail++; $display("FAIL post_reset_lock: got %h want %h", {locked, base_note, speed, direction}, {1'b1, 6'(b), 2'(spd), 2'b01});
    end
  endtask

  task automatic test_random();
    logic [6:0] q [$];
    int note, spd, nst, hl;
    bit up;
    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int s = 0; s < 12; s++) begin
        if ($urandom_range(0, 3) != 0) begin
          note = $urandom_range(0, 63);
          spd = $urandom_range(0, 3);
          up = 1'($urandom_range(0, 1));
          nst = $urandom_range(1, 8);
          for (int k = 0; k <= nst; k++) begin
            hl = spd + 1;
            if ($urandom_range(0, 7) == 0) hl = ($urandom_range(0, 1) != 0) ? hl + 1 : (hl > 1 ? hl - 1 : hl);
            for (int t = 0; t < hl; t++) begin
              while ($urandom_range(0, 5) == 0) q.push_back({1'b0, 6'($urandom_range(0, 63))});
              q.push_back({1'b1, 6'(note)});
            end
            note = up ? (note + 1) % 64 : (note + 63) % 64;
          end
        end else begin
          repeat ($urandom_range(1, 6)) q.push_back({1'b1, 6'($urandom_range(0, 63))});
        end
      end
      apply_reset();
      foreach (q[i]) begin
        drive(q[i][5:0], q[i][6]);
        n_tests++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL random r%0d s%0d: got %h want %h", r, i, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_speed1();
    test_down_break();
    test_jump_relock();
    test_wrap();
    test_valid_gap();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
